m_csr_file: RTL and testbench

- Machine-mode CSR register file, directly downstream of the CSR read/write checker in the EXE stage.
- Consumes csr_ops, csr_rd_req and csr_wr_req plus the CSR address and operand.
- Returns read data combinationally and commits read-modify-write results at the clock edge.
- Also owns trap entry/exit state (mepc/mcause/mtval/mstatus), the trap vector, and optional cycle/instret counters.

---
 rtl/m_csr_pkg.sv | 35 +++
 rtl/m_csr_counter64.sv | 28 ++
 rtl/m_csr_file.sv | 179 +++++++++++++++++
 tb/tb_m_csr_file.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, operation
// encodings, mstatus bit positions and the mtvec mode encoding.
package m_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [1:0] CSR_OPS_NONE  = 2'b00;
    localparam logic [1:0] CSR_OPS_WRITE = 2'b01;
    localparam logic [1:0] CSR_OPS_SET   = 2'b10;
    localparam logic [1:0] CSR_OPS_CLEAR = 2'b11;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvec_mode_e;

endpackage

// File: rtl/m_csr_counter64.sv
// 64-bit counter with independently writable 32-bit halves; a write to either
// half suppresses the increment of the whole counter for that cycle.
module m_csr_counter64 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) r_count[31:0]  <= i_wdata;
            if (i_wr_hi) r_count[63:32] <= i_wdata;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/m_csr_file.sv
// Machine-mode CSR register file with trap entry/exit state and trap vector.
// Optional mcycle/minstret counters are enabled by defining CSR_COUNTERS_EN.
module m_csr_file
    import m_csr_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_1100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_csr_addr,
    input  logic [1:0]  i_csr_ops,
    input  logic        i_csr_rd_req,
    input  logic        i_csr_wr_req,
    input  logic        i_csr_src_zero,
    input  logic [31:0] i_csr_wdata,
    input  logic        i_instr_retire,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_cause,
    input  logic [31:0] i_trap_pc,
    input  logic [31:0] i_trap_val,
    input  logic        i_mret,
    output logic [31:0] o_csr_rdata,
    output logic        o_illegal_csr,
    output logic [31:0] o_trap_vector,
    output logic [31:0] o_epc_out,
    output logic        o_mstatus_mie
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [31:0] w_rdata;
    logic        w_impl;
    logic [31:0] w_wval;
    logic        w_setclr;
    logic        w_wr_cand;
    logic        w_illegal;
    logic        w_we;
    mtvec_mode_e w_mtvec_mode;
    logic [31:0] w_tvec_base;

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
`endif

    always_comb begin
        w_rdata = '0;
        w_impl  = 1'b1;
        case (i_csr_addr)
            CSR_MSTATUS: begin
                w_rdata[MSTATUS_MIE_BIT]                = r_mstatus_mie;
                w_rdata[MSTATUS_MPIE_BIT]               = r_mstatus_mpie;
                w_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
            end
            CSR_MISA:     w_rdata = MISA_VAL;
            CSR_MIE:      w_rdata = r_mie;
            CSR_MTVEC:    w_rdata = r_mtvec;
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = r_mepc;
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_MTVAL:    w_rdata = r_mtval;
            CSR_MIP:      w_rdata = '0;
            CSR_MHARTID:  w_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  w_rdata = w_minstret[31:0];
            CSR_MINSTRETH: w_rdata = w_minstret[63:32];
`endif
            default:      w_impl = 1'b0;
        endcase
    end

    always_comb begin
        case (i_csr_ops)
            CSR_OPS_WRITE: w_wval = i_csr_wdata;
            CSR_OPS_SET:   w_wval = w_rdata | i_csr_wdata;
            CSR_OPS_CLEAR: w_wval = w_rdata & ~i_csr_wdata;
            default:       w_wval = w_rdata;
        endcase
    end

    // Set/clear with a zero source never writes, so it is legal on read-only CSRs.
    assign w_setclr      = (i_csr_ops == CSR_OPS_SET) || (i_csr_ops == CSR_OPS_CLEAR);
    assign w_wr_cand     = i_csr_wr_req && !(w_setclr && i_csr_src_zero);
    assign w_illegal     = (i_csr_rd_req || i_csr_wr_req) &&
                           (!w_impl || (w_wr_cand && (i_csr_addr[11:10] == 2'b11)));
    assign w_we          = w_wr_cand && !w_illegal && !i_trap_valid;
    assign w_mtvec_mode  = (w_wval[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (i_trap_valid) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (i_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_we && (i_csr_addr == CSR_MSTATUS)) begin
            r_mstatus_mie  <= w_wval[MSTATUS_MIE_BIT];
            r_mstatus_mpie <= w_wval[MSTATUS_MPIE_BIT];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
        end else if (i_trap_valid) begin
            r_mepc   <= {i_trap_pc[31:2], 2'b00};
            r_mcause <= i_trap_cause;
            r_mtval  <= i_trap_val;
        end else if (w_we) begin
            if (i_csr_addr == CSR_MEPC)   r_mepc   <= {w_wval[31:2], 2'b00};
            if (i_csr_addr == CSR_MCAUSE) r_mcause <= w_wval;
            if (i_csr_addr == CSR_MTVAL)  r_mtval  <= w_wval;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mie      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
        end else if (w_we) begin
            if (i_csr_addr == CSR_MIE)      r_mie      <= w_wval;
            if (i_csr_addr == CSR_MTVEC)    r_mtvec    <= {w_wval[31:2], w_mtvec_mode};
            if (i_csr_addr == CSR_MSCRATCH) r_mscratch <= w_wval;
        end
    end

`ifdef CSR_COUNTERS_EN
    m_csr_counter64 u_mcycle (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (1'b1),
        .i_wr_lo (w_we && (i_csr_addr == CSR_MCYCLE)),
        .i_wr_hi (w_we && (i_csr_addr == CSR_MCYCLEH)),
        .i_wdata (w_wval),
        .o_count (w_mcycle)
    );

    m_csr_counter64 u_minstret (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (i_instr_retire),
        .i_wr_lo (w_we && (i_csr_addr == CSR_MINSTRET)),
        .i_wr_hi (w_we && (i_csr_addr == CSR_MINSTRETH)),
        .i_wdata (w_wval),
        .o_count (w_minstret)
    );
`else
    logic w_unused_retire;
    assign w_unused_retire = i_instr_retire;
`endif

    // Vectored mode offsets interrupts only; cause[30:0]*4 wraps within 32 bits.
    assign w_tvec_base   = {r_mtvec[31:2], 2'b00};
    assign o_trap_vector = ((r_mtvec[1:0] == MTVEC_VECTORED) && i_trap_cause[31])
                           ? (w_tvec_base + {i_trap_cause[29:0], 2'b00})
                           : w_tvec_base;

    assign o_csr_rdata   = w_rdata;
    assign o_illegal_csr = w_illegal;
    assign o_epc_out     = r_mepc;
    assign o_mstatus_mie = r_mstatus_mie;

endmodule

// File: tb/tb_m_csr_file.sv
// Self-checking bench for m_csr_file: directed scenarios plus randomized traffic
// against a behavioural CSR model. Counter tests follow CSR_COUNTERS_EN.
module tb_m_csr_file;

    localparam logic [31:0] HART = 32'h0000_0003;
    localparam logic [31:0] MISA = 32'h4000_1100;

    logic        clk = 1'b0;
    logic        rstN;
    logic [11:0] csrAddr;
    logic [1:0]  csrOps;
    logic        csrRdReq, csrWrReq, csrSrcZero;
    logic [31:0] csrWdata;
    logic        instrRetire, trapValid, mret;
    logic [31:0] trapCause, trapPc, trapVal;
    logic [31:0] csrRdata, trapVector, epcOut;
    logic        illegalCsr, mstatusMie;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic        mMie, mMpie;
    logic [31:0] mMieReg, mMtvec, mMscratch, mMepc, mMcause, mMtval;

    always #5 clk = ~clk;

    m_csr_file #(.HART_ID(HART), .MISA_VAL(MISA)) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_csr_addr     (csrAddr),
        .i_csr_ops      (csrOps),
        .i_csr_rd_req   (csrRdReq),
        .i_csr_wr_req   (csrWrReq),
        .i_csr_src_zero (csrSrcZero),
        .i_csr_wdata    (csrWdata),
        .i_instr_retire (instrRetire),
        .i_trap_valid   (trapValid),
        .i_trap_cause   (trapCause),
        .i_trap_pc      (trapPc),
        .i_trap_val     (trapVal),
        .i_mret         (mret),
        .o_csr_rdata    (csrRdata),
        .o_illegal_csr  (illegalCsr),
        .o_trap_vector  (trapVector),
        .o_epc_out      (epcOut),
        .o_mstatus_mie  (mstatusMie)
    );

    task automatic idle();
        csrAddr = 12'h300; csrOps = 2'b00; csrRdReq = 1'b0; csrWrReq = 1'b0;
        csrSrcZero = 1'b0; csrWdata = '0; instrRetire = 1'b0; trapValid = 1'b0;
        trapCause = '0; trapPc = '0; trapVal = '0; mret = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveCsr(input logic [11:0] a, input logic [1:0] ops,
                            input logic rd, input logic wr, input logic zero,
                            input logic [31:0] d);
        csrAddr = a; csrOps = ops; csrRdReq = rd; csrWrReq = wr;
        csrSrcZero = zero; csrWdata = d;
    endtask

    task automatic applyReset();
        idle();
        rstN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        step();
        mMie = 0; mMpie = 0; mMieReg = 0; mMtvec = 0;
        mMscratch = 0; mMepc = 0; mMcause = 0; mMtval = 0;
    endtask

    function automatic logic mImpl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
            12'h342, 12'h343, 12'h344, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mRead(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(mMpie) << 7) | (32'(mMie) << 3);
            12'h301: return MISA;
            12'h304: return mMieReg;
            12'h305: return mMtvec;
            12'h340: return mMscratch;
            12'h341: return mMepc;
            12'h342: return mMcause;
            12'h343: return mMtval;
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic mIllegal(input logic [11:0] a, input logic [1:0] ops,
                                      input logic rd, input logic wr, input logic zero);
        logic cand;
        cand = wr && !((ops == 2'd2 || ops == 2'd3) && zero);
        return (rd || wr) && (!mImpl(a) || (cand && a >= 12'hC00));
    endfunction

    function automatic logic [31:0] mVector(input logic [31:0] cause);
        logic [31:0] base;
        base = mMtvec & 32'hFFFF_FFFC;
        if ((mMtvec & 32'h3) == 32'h1 && cause[31])
            base = base + (cause & 32'h7FFF_FFFF) * 32'd4;
        return base;
    endfunction

    task automatic modelCommit(input logic [11:0] a, input logic [1:0] ops,
                               input logic wr, input logic zero, input logic [31:0] d,
                               input logic ill, input logic trap, input logic [31:0] cause,
                               input logic [31:0] pc, input logic [31:0] tval, input logic ret);
        logic [31:0] oldV, newV;
        if (trap) begin
            mMepc = pc & 32'hFFFF_FFFC; mMcause = cause; mMtval = tval;
            mMpie = mMie; mMie = 0;
        end else begin
            if (ret) begin mMie = mMpie; mMpie = 1; end
            if (wr && !ill && !((ops == 2'd2 || ops == 2'd3) && zero)) begin
                oldV = mRead(a);
                case (ops)
                    2'd1: newV = d;
                    2'd2: newV = oldV | d;
                    2'd3: newV = oldV & ~d;
                    default: newV = oldV;
                endcase
                case (a)
                    12'h300: begin mMie = newV[3]; mMpie = newV[7]; end
                    12'h304: mMieReg = newV;
                    12'h305: mMtvec = (newV[1:0] == 2'b01) ? newV : (newV & 32'hFFFF_FFFC);
                    12'h340: mMscratch = newV;
                    12'h341: mMepc = newV & 32'hFFFF_FFFC;
                    12'h342: mMcause = newV;
                    12'h343: mMtval = newV;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic test_reset();
        idle();
        rstN = 1'b0;
        csrRdReq = 1'b1;
        #2;
        checks++;
        if (csrRdata !== 32'h0000_1800) begin
            failures++; $display("[TB] FAIL reset_mstatus: got %h expected %h", csrRdata, 32'h1800);
        end
        checks++;
        if (illegalCsr !== 1'b0 || epcOut !== 32'h0 || mstatusMie !== 1'b0 || trapVector !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got ill=%b epc=%h mie=%b vec=%h expected 0/0/0/0",
                     illegalCsr, epcOut, mstatusMie, trapVector);
        end
        applyReset();
        driveCsr(12'h340, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checks++;
        if (csrRdata !== 32'h0) begin
            failures++; $display("[TB] FAIL reset_mscratch: got %h expected 0", csrRdata);
        end
        idle();
    endtask

    task automatic test_write_read();
        driveCsr(12'h340, 2'b01, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (csrRdata !== 32'h0) begin
            failures++; $display("[TB] FAIL write_cycle_old: got %h expected 0", csrRdata);
        end
        step();
        driveCsr(12'h340, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checks++;
        if (csrRdata !== 32'hDEAD_BEEF) begin
            failures++; $display("[TB] FAIL write_read: got %h expected DEADBEEF", csrRdata);
        end
        idle();
    endtask

    task automatic test_set_clear();
        driveCsr(12'h340, 2'b01, 1'b0, 1'b1, 1'b0, 32'hF0F0_F0F0); step();
        driveCsr(12'h340, 2'b10, 1'b1, 1'b1, 1'b0, 32'h0000_000F); step();
        driveCsr(12'h340, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'hF0F0_F0FF) begin
            failures++; $display("[TB] FAIL set: got %h expected F0F0F0FF", csrRdata);
        end
        driveCsr(12'h340, 2'b11, 1'b1, 1'b1, 1'b0, 32'hF000_0000); step();
        driveCsr(12'h340, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'h00F0_F0FF) begin
            failures++; $display("[TB] FAIL clear: got %h expected 00F0F0FF", csrRdata);
        end
        idle();
    endtask

    task automatic test_readonly();
        driveCsr(12'hF14, 2'b01, 1'b1, 1'b1, 1'b0, 32'h1234_5678); #1;
        checks++;
        if (illegalCsr !== 1'b1) begin
            failures++; $display("[TB] FAIL ro_write_illegal: got %b expected 1", illegalCsr);
        end
        step();
        driveCsr(12'hF14, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0); #1;
        checks++;
        if (illegalCsr !== 1'b0 || csrRdata !== HART) begin
            failures++; $display("[TB] FAIL ro_set_zero: got ill=%b rdata=%h expected 0/%h", illegalCsr, csrRdata, HART);
        end
        driveCsr(12'h7C0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (illegalCsr !== 1'b1) begin
            failures++; $display("[TB] FAIL unimpl_read: got %b expected 1", illegalCsr);
        end
        driveCsr(12'h7C0, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (illegalCsr !== 1'b0) begin
            failures++; $display("[TB] FAIL no_request: got %b expected 0", illegalCsr);
        end
        driveCsr(12'h301, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== MISA || illegalCsr !== 1'b0) begin
            failures++; $display("[TB] FAIL misa: got %h expected %h", csrRdata, MISA);
        end
        idle();
    endtask

    task automatic test_trap_mret();
        driveCsr(12'h300, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_0008); step();
        driveCsr(12'h305, 2'b01, 1'b0, 1'b1, 1'b0, 32'h8000_0101); step();
        idle();
        driveCsr(12'h340, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
        trapValid = 1'b1; trapCause = 32'h8000_0007; trapPc = 32'h0000_1002; trapVal = 32'h55;
        #1;
        checks++;
        if (trapVector !== 32'h8000_011C) begin
            failures++; $display("[TB] FAIL trap_vector: got %h expected 8000011C", trapVector);
        end
        step();
        idle();
        driveCsr(12'h300, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (epcOut !== 32'h1000 || mstatusMie !== 1'b0 || csrRdata !== 32'h0000_1880) begin
            failures++; $display("[TB] FAIL trap_entry: got epc=%h mie=%b mstatus=%h expected 1000/0/00001880",
                                 epcOut, mstatusMie, csrRdata);
        end
        driveCsr(12'h342, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'h8000_0007) begin
            failures++; $display("[TB] FAIL trap_mcause: got %h expected 80000007", csrRdata);
        end
        mret = 1'b1; step(); idle();
        driveCsr(12'h300, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (mstatusMie !== 1'b1 || csrRdata !== 32'h0000_1888) begin
            failures++; $display("[TB] FAIL mret: got mie=%b mstatus=%h expected 1/00001888", mstatusMie, csrRdata);
        end
        driveCsr(12'h305, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_0012); step();
        driveCsr(12'h305, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
        trapCause = 32'h8000_0007; #1;
        checks++;
        if (csrRdata !== 32'h0000_0010 || trapVector !== 32'h0000_0010) begin
            failures++; $display("[TB] FAIL mtvec_warl: got mtvec=%h vec=%h expected 00000010/00000010", csrRdata, trapVector);
        end
        idle();
    endtask

    task automatic test_trap_vs_write();
        driveCsr(12'h341, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_2000);
        trapValid = 1'b1; trapCause = 32'h2; trapPc = 32'h0000_3006; trapVal = 32'h0;
        step(); idle();
        driveCsr(12'h341, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'h0000_3004 || epcOut !== 32'h0000_3004) begin
            failures++; $display("[TB] FAIL trap_vs_write: got %h expected 00003004", csrRdata);
        end
        driveCsr(12'h340, 2'b01, 1'b0, 1'b1, 1'b0, 32'h1111_1111);
        trapValid = 1'b1; trapCause = 32'h3;
        step(); idle();
        driveCsr(12'h340, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'h00F0_F0FF) begin
            failures++; $display("[TB] FAIL trap_blocks_write: got %h expected 00F0F0FF", csrRdata);
        end
        idle();
    endtask

`ifdef CSR_COUNTERS_EN
    task automatic test_counters();
        int retired;
        driveCsr(12'hB00, 2'b01, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF); step();
        driveCsr(12'hB80, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0); step();
        driveCsr(12'hB00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'hFFFF_FFFF) begin
            failures++; $display("[TB] FAIL mcycle_preset: got %h expected FFFFFFFF", csrRdata);
        end
        step();
        driveCsr(12'hB00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'h0) begin
            failures++; $display("[TB] FAIL mcycle_carry_lo: got %h expected 0", csrRdata);
        end
        driveCsr(12'hB80, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'h1) begin
            failures++; $display("[TB] FAIL mcycle_carry_hi: got %h expected 1", csrRdata);
        end
        driveCsr(12'hB00, 2'b01, 1'b1, 1'b1, 1'b0, 32'h5); step();
        driveCsr(12'hB00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'h5) begin
            failures++; $display("[TB] FAIL mcycle_write: got %h expected 5", csrRdata);
        end
        driveCsr(12'hB02, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0); instrRetire = 1'b1; step();
        driveCsr(12'hB82, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0); instrRetire = 1'b1; step();
        idle();
        retired = 0;
        for (int i = 0; i < 40; i++) begin
            instrRetire = 1'($urandom_range(0, 1));
            if (instrRetire) retired++;
            step();
        end
        idle();
        driveCsr(12'hB02, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (csrRdata !== 32'(retired)) begin
            failures++; $display("[TB] FAIL minstret: got %0d expected %0d", csrRdata, retired);
        end
        idle();
    endtask
`else
    task automatic test_counter_absent();
        driveCsr(12'hB00, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0); #1;
        checks++;
        if (illegalCsr !== 1'b1) begin
            failures++; $display("[TB] FAIL mcycle_absent: got %b expected 1", illegalCsr);
        end
        driveCsr(12'hB82, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0); #1;
        checks++;
        if (illegalCsr !== 1'b1) begin
            failures++; $display("[TB] FAIL minstreth_absent: got %b expected 1", illegalCsr);
        end
        idle();
    endtask
`endif

    task automatic test_random();
        logic [11:0] pool [13];
        logic [11:0] a;
        logic [1:0]  ops;
        logic        rd, wr, zero, trap, ret, expIll;
        logic [31:0] d, cause, pc, tval, expR;
        pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                 12'h343, 12'h344, 12'hF14, 12'hF11, 12'h7C0, 12'h000};
        applyReset();
        for (int i = 0; i < 300; i++) begin
            a     = pool[$urandom_range(0, 12)];
            ops   = 2'($urandom_range(0, 3));
            rd    = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            zero  = ($urandom_range(0, 3) == 0);
            d     = zero ? 32'h0 : $urandom;
            trap  = ($urandom_range(0, 7) == 0);
            ret   = !wr && ($urandom_range(0, 7) == 0);
            cause = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 40))};
            pc    = $urandom;
            tval  = $urandom;
            driveCsr(a, ops, rd, wr, zero, d);
            trapValid = trap; trapCause = cause; trapPc = pc; trapVal = tval; mret = ret;
            #1;
            expIll = mIllegal(a, ops, rd, wr, zero);
            expR   = mRead(a);
            checks++;
            if (illegalCsr !== expIll) begin
                failures++; $display("[TB] FAIL rand_illegal[%0d] addr=%h: got %b expected %b", i, a, illegalCsr, expIll);
            end
            if (mImpl(a)) begin
                checks++;
                if (csrRdata !== expR) begin
                    failures++; $display("[TB] FAIL rand_rdata[%0d] addr=%h: got %h expected %h", i, a, csrRdata, expR);
                end
            end
            checks++;
            if (trapVector !== mVector(cause) || epcOut !== mMepc || mstatusMie !== mMie) begin
                failures++;
                $display("[TB] FAIL rand_state[%0d]: got vec=%h epc=%h mie=%b expected %h/%h/%b",
                         i, trapVector, epcOut, mstatusMie, mVector(cause), mMepc, mMie);
            end
            modelCommit(a, ops, wr, zero, d, expIll, trap, cause, pc, tval, ret);
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_set_clear();
        test_readonly();
        test_trap_mret();
        test_trap_vs_write();
`ifdef CSR_COUNTERS_EN
        test_counters();
`else
        test_counter_absent();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
